// File: rtl/prio_age_arbiter.sv
// Registered priority arbiter with round-robin tie-break, grant hold until release,
// and per-channel age counters that lift starved requesters above all priorities.
module prio_age_arbiter #(
  parameter int N         = 8,
  parameter int PRIO_BITS = 3,
  parameter int AGE_BITS  = 4,
  parameter int SEL_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N-1:0]           req_i,
  input  logic [N*PRIO_BITS-1:0] prio_i,
  input  logic                   ack_i,
  output logic [N-1:0]           gnt_o,
  output logic                   gnt_valid_o,
  output logic [SEL_W-1:0]       sel_o,
  output logic [PRIO_BITS-1:0]   prio_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [AGE_BITS-1:0] AGE_MAX = {AGE_BITS{1'b1}};

  state_t                 state_q;
  logic [N-1:0]           gnt_q;
  logic                   valid_q;
  logic [SEL_W-1:0]       sel_q;
  logic [PRIO_BITS-1:0]   prio_q;
  logic [SEL_W-1:0]       rr_q;
  logic [SEL_W-1:0]       rr_d;
  logic [AGE_BITS-1:0]    age_q [N];
  logic [AGE_BITS-1:0]    age_d [N];

  logic [N-1:0]           starved_s;
  logic [N-1:0]           tied_s;
  logic [N-1:0]           cand_s;
  logic [N-1:0]           onehot_s;
  logic [PRIO_BITS-1:0]   min_prio_s;
  logic [PRIO_BITS-1:0]   win_prio_s;
  logic [SEL_W-1:0]       win_s;
  logic [SEL_W:0]         idx_s;
  logic                   found_s;
  logic                   release_s;
  logic                   holder_free_s;
  logic                   arb_s;

  // Find the lowest requested priority and the set of saturated-age requesters.
  always_comb begin
    min_prio_s = {PRIO_BITS{1'b1}};
    starved_s  = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      starved_s[i] = req_i[i] && (age_q[i] == AGE_MAX);
      if (req_i[i] && (prio_i[i*PRIO_BITS +: PRIO_BITS] < min_prio_s)) begin
        min_prio_s = prio_i[i*PRIO_BITS +: PRIO_BITS];
      end else begin
        min_prio_s = min_prio_s;
      end
    end
  end

  // Starved requesters, when present, compete alone and ignore priority.
  always_comb begin
    tied_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      tied_s[i] = req_i[i] && (prio_i[i*PRIO_BITS +: PRIO_BITS] == min_prio_s);
    end
    cand_s = (|starved_s) ? starved_s : tied_s;
  end

  // Rotating scan from rr_q; idx_s is one bit wider so the wrap works for any N.
  always_comb begin
    win_s   = {SEL_W{1'b0}};
    found_s = 1'b0;
    idx_s   = {(SEL_W+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, rr_q} + (SEL_W+1)'(k);
      if (idx_s >= (SEL_W+1)'(N)) begin
        idx_s = idx_s - (SEL_W+1)'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && cand_s[idx_s[SEL_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[SEL_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Winner decode: one-hot grant vector, captured priority and next pointer.
  always_comb begin
    onehot_s   = {N{1'b0}};
    win_prio_s = {PRIO_BITS{1'b0}};
    for (int i = 0; i < N; i++) begin
      onehot_s[i] = (win_s == SEL_W'(i));
      if (onehot_s[i]) begin
        win_prio_s = prio_i[i*PRIO_BITS +: PRIO_BITS];
      end else begin
        win_prio_s = win_prio_s;
      end
    end
    if (win_s == SEL_W'(N-1)) begin
      rr_d = {SEL_W{1'b0}};
    end else begin
      rr_d = win_s + SEL_W'(1'b1);
    end
  end

  assign release_s     = (state_q == ST_GRANT) && (ack_i || !req_i[sel_q]);
  assign holder_free_s = (state_q == ST_IDLE) || release_s;
  assign arb_s         = holder_free_s && (|req_i);

  // Age update: idle channels reset, losers of an arbitration age by one.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (!req_i[i]) begin
        age_d[i] = {AGE_BITS{1'b0}};
      end else if (arb_s && onehot_s[i]) begin
        age_d[i] = {AGE_BITS{1'b0}};
      end else if (arb_s && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + {{(AGE_BITS-1){1'b0}}, 1'b1};
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  // Grant FSM with registered outputs and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= {N{1'b0}};
      valid_q <= 1'b0;
      sel_q   <= {SEL_W{1'b0}};
      prio_q  <= {PRIO_BITS{1'b0}};
      rr_q    <= {SEL_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_s) begin
            state_q <= ST_GRANT;
            gnt_q   <= onehot_s;
            valid_q <= 1'b1;
            sel_q   <= win_s;
            prio_q  <= win_prio_s;
            rr_q    <= rr_d;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (arb_s) begin
            state_q <= ST_GRANT;
            gnt_q   <= onehot_s;
            valid_q <= 1'b1;
            sel_q   <= win_s;
            prio_q  <= win_prio_s;
            rr_q    <= rr_d;
          end else if (release_s) begin
            state_q <= ST_IDLE;
            gnt_q   <= {N{1'b0}};
            valid_q <= 1'b0;
            sel_q   <= {SEL_W{1'b0}};
            prio_q  <= {PRIO_BITS{1'b0}};
          end else begin
            state_q <= ST_GRANT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= {N{1'b0}};
          valid_q <= 1'b0;
          sel_q   <= {SEL_W{1'b0}};
          prio_q  <= {PRIO_BITS{1'b0}};
          rr_q    <= {SEL_W{1'b0}};
        end
      endcase
    end
  end

  // Age counter storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= {AGE_BITS{1'b0}};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = valid_q;
  assign sel_o       = sel_q;
  assign prio_o      = prio_q;

endmodule
